// File: rtl/spad_pkg.sv
// Shared types and arithmetic helpers for the PE scratchpad and PE accumulators.
package spad_pkg;

    // Write flavour carried down the write pipeline
    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_ACCUM     = 1'b1
    } wr_mode_e;

    // Scratchpad control state: normal operation or hardware zeroing sweep
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } spad_state_e;

    // Widest word the generic adder handles; the 64-bit intermediate needs headroom
    localparam int unsigned SAT_MAX_WIDTH = 62;

    // Signed add of two width-bit two's complement words held in the low bits of
    // 64-bit containers. With saturate set the result clamps to the signed range,
    // otherwise the caller keeps the low width bits, which gives modulo wrap.
    function automatic logic [63:0] satAdd(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned width,
        input bit          saturate
    );
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sum;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        int unsigned        shiftAmt;
        shiftAmt = 64 - width;
        sa       = $signed(a << shiftAmt) >>> shiftAmt;
        sb       = $signed(b << shiftAmt) >>> shiftAmt;
        sum      = sa + sb;
        maxV     = (64'sd1 <<< (width - 1)) - 64'sd1;
        minV     = -maxV - 64'sd1;
        if (saturate) begin
            if (sum > maxV) begin
                sum = maxV;
            end else if (sum < minV) begin
                sum = minV;
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/spad_sat_adder.sv
// Combinational signed adder with optional saturation, shared by the scratchpad
// accumulate path and the PE accumulators.
module spad_sat_adder
    import spad_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter bit SATURATE      = 1'b0
) (
    input  logic [DATA_BITWIDTH-1:0] i_a,
    input  logic [DATA_BITWIDTH-1:0] i_b,
    output logic [DATA_BITWIDTH-1:0] o_sum
);

    // Truncating the wide result to the word width is what produces wrap mode
    assign o_sum = DATA_BITWIDTH'(satAdd(64'(i_a), 64'(i_b), DATA_BITWIDTH, SATURATE));

endmodule

// File: rtl/spad_accum_memory.sv
// Per-PE scratchpad: registered read, overwrite/accumulate write pipeline with
// same-address forwarding, and a hardware clear sweep that zeroes every word.
module spad_accum_memory
    import spad_pkg::*;
#(
    parameter int DATA_BITWIDTH    = 16,
    parameter int ADDRESS_BITWIDTH = 9,
    parameter int IDLE_DATA        = 10101,
    parameter bit SATURATE         = 1'b0,
    parameter bit CLEAR_ON_RESET   = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear_req,
    output logic                        o_busy,
    input  logic                        i_read_request,
    input  logic [ADDRESS_BITWIDTH-1:0] i_read_address,
    output logic [DATA_BITWIDTH-1:0]    o_read_data,
    output logic                        o_read_valid,
    input  logic                        i_write_enable,
    input  logic                        i_write_mode,
    input  logic [ADDRESS_BITWIDTH-1:0] i_write_address,
    input  logic [DATA_BITWIDTH-1:0]    i_write_data
);

    localparam int                          DEPTH       = 2 ** ADDRESS_BITWIDTH;
    localparam logic [ADDRESS_BITWIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [DATA_BITWIDTH-1:0]    IDLE_WORD   = DATA_BITWIDTH'(IDLE_DATA);
    localparam spad_state_e                 RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [DATA_BITWIDTH-1:0]    r_mem [DEPTH];

    spad_state_e                 r_state;
    logic [ADDRESS_BITWIDTH-1:0] r_clear_addr;

    // Write stage 2: operands captured from the accepted request
    logic                        r_s2_valid;
    logic [ADDRESS_BITWIDTH-1:0] r_s2_addr;
    logic [DATA_BITWIDTH-1:0]    r_s2_data;
    wr_mode_e                    r_s2_mode;

    // Result of the previous stage-2 commit, used as the old operand on a repeat address
    logic                        r_fwd_valid;
    logic [ADDRESS_BITWIDTH-1:0] r_fwd_addr;
    logic [DATA_BITWIDTH-1:0]    r_fwd_data;

    logic [DATA_BITWIDTH-1:0]    r_read_data;
    logic                        r_read_valid;

    logic                        w_busy;
    logic                        w_accept;
    logic                        w_commit;
    logic [DATA_BITWIDTH-1:0]    w_old;
    logic [DATA_BITWIDTH-1:0]    w_sum;
    logic [DATA_BITWIDTH-1:0]    w_new;
    logic                        w_read_hit;

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_accept = i_write_enable && !w_busy;
    // A stage-2 write landing during the sweep is dropped; the sweep zeroes that word anyway
    assign w_commit = r_s2_valid && !w_busy && i_reset;

    assign w_old      = (r_fwd_valid && (r_fwd_addr == r_s2_addr)) ? r_fwd_data : r_mem[r_s2_addr];
    assign w_new      = (r_s2_mode == WR_ACCUM) ? w_sum : r_s2_data;
    assign w_read_hit = w_commit && (r_s2_addr == i_read_address);

    spad_sat_adder #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .SATURATE      (SATURATE)
    ) u_adder (
        .i_a   (w_old),
        .i_b   (r_s2_data),
        .o_sum (w_sum)
    );

    // Clear sequencer: sweep every address once, then return to normal operation
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= RESET_STATE;
            r_clear_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state      <= ST_CLEAR;
                        r_clear_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clear_addr <= r_clear_addr + ADDRESS_BITWIDTH'(1);
                    if (r_clear_addr == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write pipeline registers and the forwarding copy of the last committed word
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_s2_valid  <= 1'b0;
            r_fwd_valid <= 1'b0;
        end else begin
            r_s2_valid  <= w_accept;
            r_fwd_valid <= w_commit;
            if (w_accept) begin
                r_s2_addr <= i_write_address;
                r_s2_data <= i_write_data;
                r_s2_mode <= wr_mode_e'(i_write_mode);
            end
            if (w_commit) begin
                r_fwd_addr <= r_s2_addr;
                r_fwd_data <= w_new;
            end
        end
    end

    // Storage array: sweep zeroes or stage-2 commit, contents themselves are never reset
    always_ff @(posedge i_clk) begin
        if (w_busy && i_reset) begin
            r_mem[r_clear_addr] <= '0;
        end else if (w_commit) begin
            r_mem[r_s2_addr] <= w_new;
        end
    end

    // Registered read port; a same-cycle stage-2 commit is visible to the read
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else if (w_busy || !i_read_request) begin
            r_read_data  <= IDLE_WORD;
            r_read_valid <= 1'b0;
        end else begin
            r_read_data  <= w_read_hit ? w_new : r_mem[i_read_address];
            r_read_valid <= 1'b1;
        end
    end

    assign o_busy       = w_busy;
    assign o_read_data  = r_read_data;
    assign o_read_valid = r_read_valid;

endmodule

// File: tb/tb_spad_accum_memory.sv
// Directed bench for the PE scratchpad: one wrapping and one saturating instance
// driven by the same stimulus, checked against hand-computed values.
module tb_spad_accum_memory;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam logic [31:0] IDLE_VAL = 32'd10101;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clearReq = 1'b0;
    logic          readRequest = 1'b0;
    logic [AW-1:0] readAddress = '0;
    logic          writeEnable = 1'b0;
    logic          writeMode = 1'b0;
    logic [AW-1:0] writeAddress = '0;
    logic [DW-1:0] writeData = '0;

    logic          busyW, busyS;
    logic [DW-1:0] readDataW, readDataS;
    logic          readValidW, readValidS;

    int checkCount = 0;
    int passCount  = 0;

    // Free-running clock
    always #5 clock = ~clock;

    spad_accum_memory #(
        .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .IDLE_DATA(10101),
        .SATURATE(1'b0), .CLEAR_ON_RESET(1'b1)
    ) dutWrap (
        .i_clk(clock), .i_reset(reset), .i_clear_req(clearReq), .o_busy(busyW),
        .i_read_request(readRequest), .i_read_address(readAddress),
        .o_read_data(readDataW), .o_read_valid(readValidW),
        .i_write_enable(writeEnable), .i_write_mode(writeMode),
        .i_write_address(writeAddress), .i_write_data(writeData)
    );

    spad_accum_memory #(
        .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .IDLE_DATA(10101),
        .SATURATE(1'b1), .CLEAR_ON_RESET(1'b1)
    ) dutSat (
        .i_clk(clock), .i_reset(reset), .i_clear_req(clearReq), .o_busy(busyS),
        .i_read_request(readRequest), .i_read_address(readAddress),
        .o_read_data(readDataS), .o_read_valid(readValidS),
        .i_write_enable(writeEnable), .i_write_mode(writeMode),
        .i_write_address(writeAddress), .i_write_data(writeData)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of write/read strobes, then advance past the clock edge
    task automatic applyStimulus(input logic we, input logic mode, input logic [AW-1:0] wAddr,
                                 input logic [DW-1:0] wData, input logic rReq, input logic [AW-1:0] rAddr);
        writeEnable  = we;
        writeMode    = mode;
        writeAddress = wAddr;
        writeData    = wData;
        readRequest  = rReq;
        readAddress  = rAddr;
        tick();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Count remaining busy cycles with a bound so a stuck sweep still reaches the summary
    task automatic waitClear(input string tag, input int expectedCycles);
        int n;
        n = 0;
        idleCycle();
        n = 1;
        while ((busyW || busyS) && n < 2000) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(n), 32'(expectedCycles));
    endtask

    task automatic checkRead(input string tag, input logic [DW-1:0] expW, input logic [DW-1:0] expS);
        checkOutput({tag, ".wrap.data"}, 32'(readDataW), 32'(expW));
        checkOutput({tag, ".wrap.valid"}, 32'(readValidW), 32'd1);
        checkOutput({tag, ".sat.data"}, 32'(readDataS), 32'(expS));
        checkOutput({tag, ".sat.valid"}, 32'(readValidS), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("reset.data", 32'(readDataW), 32'd0);
        checkOutput("reset.valid", 32'(readValidW), 32'd0);
        checkOutput("reset.busy", 32'(busyW), 32'd1);
        checkOutput("reset.sat.busy", 32'(busyS), 32'd1);
        reset = 1'b1;
        checkOutput("clear.busy_first", 32'(busyW), 32'd1);
        waitClear("clear.reset_cycles", 512);

        // Reads of cleared memory at low, middle and top addresses
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd0);
        checkRead("rd0", 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd255);
        checkRead("rd255", 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd511);
        checkRead("rd511", 16'h0000, 16'h0000);

        // Non-read cycle drives the idle word
        idleCycle();
        checkOutput("idle.data", 32'(readDataW), IDLE_VAL);
        checkOutput("idle.valid", 32'(readValidW), 32'd0);

        // Overwrite: same-cycle read sees old value, next-cycle read sees the forwarded write
        applyStimulus(1'b1, 1'b0, 9'd5, 16'h1234, 1'b1, 9'd5);
        checkRead("ovw.same_cycle", 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd5);
        checkRead("ovw.next_cycle", 16'h1234, 16'h1234);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd5);
        checkRead("ovw.committed", 16'h1234, 16'h1234);

        // Back-to-back accumulates 3, 4, 5 to one address
        applyStimulus(1'b1, 1'b1, 9'd7, 16'd3, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd7, 16'd4, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd7, 16'd5, 1'b1, 9'd7);
        checkRead("acc.partial", 16'd7, 16'd7);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
        checkRead("acc.forward", 16'd12, 16'd12);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
        checkRead("acc.committed", 16'd12, 16'd12);

        // Positive overflow: 0x7FF0 + 0x0100
        applyStimulus(1'b1, 1'b0, 9'd9, 16'h7FF0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd9, 16'h0100, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd9);
        checkRead("sat.pos", 16'h80F0, 16'h7FFF);

        // Negative overflow: 0x8010 + 0xFF00
        applyStimulus(1'b1, 1'b0, 9'd10, 16'h8010, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 9'd10, 16'hFF00, 1'b0, '0);
        idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd10);
        checkRead("sat.neg", 16'h7F10, 16'h8000);

        // In-range signed accumulate: 5 + (-10)
        applyStimulus(1'b1, 1'b0, 9'd11, 16'd5, 1'b0, '0);
        idleCycle();
        applyStimulus(1'b1, 1'b1, 9'd11, 16'hFFF6, 1'b0, '0);
        idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd11);
        checkRead("acc.neg", 16'hFFFB, 16'hFFFB);

        // Clear request with a write in flight; accesses during the sweep are ignored
        clearReq = 1'b1;
        applyStimulus(1'b1, 1'b0, 9'd20, 16'h4321, 1'b0, '0);
        clearReq = 1'b0;
        checkOutput("clr.busy", 32'(busyW), 32'd1);
        applyStimulus(1'b1, 1'b0, 9'd30, 16'hAAAA, 1'b1, 9'd5);
        checkOutput("clr.read_valid", 32'(readValidW), 32'd0);
        checkOutput("clr.read_data", 32'(readDataW), IDLE_VAL);
        waitClear("clr.cycles", 511);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd30);
        checkRead("clr.ignored_write", 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd20);
        checkRead("clr.inflight_write", 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
        checkRead("clr.old_data", 16'h0000, 16'h0000);

        // Reset while both pipeline stages hold writes to address 3
        applyStimulus(1'b1, 1'b0, 9'd3, 16'h0777, 1'b0, '0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 9'd3, 16'h0111, 1'b0, '0);
        checkOutput("midrst.busy", 32'(busyW), 32'd1);
        checkOutput("midrst.data", 32'(readDataW), 32'd0);
        reset = 1'b1;
        waitClear("midrst.cycles", 512);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd3);
        checkRead("midrst.addr3", 16'h0000, 16'h0000);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 9'd3);
        checkRead("midrst.addr3_late", 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spad_accum_memory.md
# spad_accum_memory

Parametrised successor scratchpad for the DNN PE array: single-port-read, single-port-write SRAM model with a two-stage write pipeline that supports overwrite or accumulate (partial-sum) writes with same-address forwarding, optional saturation, a registered read with valid flag, and a hardware clear sequencer. It sits beside each PE, holding weights, ifmap rows or partial sums, and replaces manual zeroing of psum memory by the controller.

## Interface
- DATA_BITWIDTH, 16, word width (two's complement for accumulate)
- ADDRESS_BITWIDTH, 9, depth = 2^ADDRESS_BITWIDTH words
- IDLE_DATA, 10101, value driven on read_data in cycles after a non-read
- SATURATE, 0, 1 = accumulate clamps to signed max/min; 0 = wraps modulo 2^DATA_BITWIDTH
- CLEAR_ON_RESET, 1, 1 = clear sequence starts automatically when reset deasserts
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- clear_req  in  1  pulse: zero the whole memory
- busy  out  1  high while clearing; reads/writes ignored
- read_request  in  1  read strobe
- read_address  in  ADDRESS_BITWIDTH  read address
- read_data  out  DATA_BITWIDTH  registered read data
- read_valid  out  1  read_data holds a requested word
- write_enable  in  1  write strobe
- write_mode  in  1  0 = overwrite, 1 = accumulate (mem += write_data)
- write_address  in  ADDRESS_BITWIDTH  write address
- write_data  in  DATA_BITWIDTH  write operand

## Operation
- FSM states: IDLE, CLEAR. Reset → CLEAR if CLEAR_ON_RESET else IDLE. IDLE → CLEAR on clear_req (sampled only in IDLE). CLEAR writes 0 to address counter, counter increments 0..2^A−1, → IDLE after last address.
- busy = (state == CLEAR). While busy: read_request and write_enable ignored, read_valid = 0, read_data = IDLE_DATA.
- Write pipeline: stage 1 (S1) captures {addr, data, mode} when write_enable && !busy. Stage 2 (S2) computes new = mode ? old + data : data and commits to memory at end of its cycle.
- old operand for S2: if previous S2 was valid with same address, use previous S2 result (forward); else memory[addr]. Back-to-back accumulates to one address therefore sum correctly at full rate.
- Accumulate arithmetic: DATA_BITWIDTH+1-bit signed sum; SATURATE=1 clamps to 0x7FFF / 0x8000 (for 16 bit), else truncate low bits.
- Read: read_data <= memory[read_address], but forwarded from S2 result if S2 is valid to the same address in that cycle (S2 commit is visible). A write still in S1 is not visible (read-first against S1).
- Non-read cycle (not busy): read_data <= IDLE_DATA, read_valid <= 0.
- Memory contents are not reset; only CLEAR zeroes them.
- Reset mid-clear or mid-write: pipeline valids drop, pending S1/S2 writes are discarded, FSM re-enters per CLEAR_ON_RESET.
- clear_req while a write is in S2: S2 still commits, then CLEAR overwrites with 0.

## Timing
- Reset values: read_data = 0, read_valid = 0, busy = 1 first cycle after reset if CLEAR_ON_RESET else 0; S1/S2 valid = 0.
- Read latency 1: request in cycle N → read_data/read_valid in N+1.
- Write latency: accepted cycle N, in S2 cycle N+1, memory updated at edge ending N+1; read requested in N+1 returns it (forward), read in N does not.
- Clear duration: exactly 2^ADDRESS_BITWIDTH cycles of busy (512 default); first accepted access in the cycle busy is low.
- Throughput: one read and one write per cycle, any address mix.

## Structure
- Shared package spad_pkg: write_mode enum (WR_OVERWRITE, WR_ACCUM), FSM state enum, saturating-add function.
- One sub-module: spad_sat_adder (combinational signed add with SATURATE parameter), reused by PE accumulators.
- Memory array, write pipeline, forwarding mux and clear FSM stay in the top module.

## Test plan
- Reset with CLEAR_ON_RESET=1 → busy high 512 cycles, then reads of addresses 0, 255, 511 return 0 with read_valid=1 one cycle later.
- Overwrite 0x1234 to addr 5 cycle N, read addr 5 cycle N+1 → read_data 0x1234 in N+2; read in N → old value 0.
- Accumulate 3, 4, 5 to addr 7 on three consecutive cycles from 0 → read returns 12 (forwarding across S2).
- SATURATE=1: addr 9 = 0x7FF0, accumulate 0x0100 → 0x7FFF; SATURATE=0 → 0x80F0.
- Idle cycle (no read_request) → read_data 10101, read_valid 0; reads/writes during busy after clear_req ignored, write of 0xAAAA during clear leaves 0.
- Assert reset (low) while S1 and S2 hold writes to addr 3 → after reset/clear addr 3 reads 0, no late commit.
